archon_hazard_override_engine: RTL and testbench
================================================

// Module: archon_hazard_override_engine
// PURPOSE
// Parametrised successor of the AHO scorer: NUM_CH hazard metrics, per-mode runtime-programmable weights, 2-stage score
// pipeline, stateful override FSM with hysteresis and anomaly hold-off. Feeds flush/stall requests to the Probabilistic Hazard FSM.
// PARAMETERS
// NUM_CH      5   number of metric channels
// MW          8   metric width (bits)
// WW          4   weight width (bits)
// NUM_MODES   4   ML risk modes (power of 2); MODEW = clog2(NUM_MODES)
// HOLD_CYCLES 8   flush hold after anomaly (>=1)
// CNT_W       16  event counter width
// SW (local)  MW+WW+clog2(NUM_CH): exact score width, cannot overflow
// PORTS
// clk              in   1            clock, all state on rising edge
// rst              in   1            async active-high reset
// metric_valid     in   1            metrics/anomaly/mode valid this cycle
// metrics_flat     in   NUM_CH*MW    channel i = bits [i*MW +: MW]
// anomaly_in       in   1            anomaly flag, qualified by metric_valid
// mode             in   MODEW        ML predicted action selecting weight set
// cfg_we           in   1            weight write strobe
// cfg_mode         in   MODEW        weight set to write
// cfg_ch           in   clog2(NUM_CH) channel to write
// cfg_weight       in   WW           weight value
// flush_thresh     in   SW           flush threshold
// stall_thresh     in   SW           stall threshold
// hyst             in   SW           hysteresis margin
// score_out        out  SW           last computed score
// score_valid      out  1            score_out updated this cycle
// override_flush   out  1            flush request
// override_stall   out  1            stall request
// hazard_level     out  2            00 none, 01 stall, 10 flush, 11 critical
// flush_events     out  CNT_W        saturating count of entries into FLUSH/CRIT
// BEHAVIOUR
// - Reset: all outputs 0, state NORM, pipeline valids 0, every weight = 2**(WW-1), hold counter 0. In-flight samples discarded.
// - Weight table NUM_MODES x NUM_CH x WW regs. cfg_we writes at edge; cfg_ch >= NUM_CH ignored. Sample in the same cycle as a write uses the old weight.
// - S1 (edge after metric_valid): product[i] = metric[i]*W[mode][i] (MW+WW bits, unsigned); anomaly, valid piped along.
// - S2: score = sum of products, zero-extended to SW; score_valid=1 for one cycle. metric_valid cycle 0 -> score_valid cycle 2.
// - FSM updates at the edge after score_valid (outputs valid cycle 3); thresholds/hyst sampled while score_valid=1.
//   lo(t) = (t > hyst) ? t-hyst : 0 (saturating).
//   any state, anomaly: -> CRIT, hold_cnt = HOLD_CYCLES (reloads if already in CRIT).
//   NORM:  score>flush_thresh -> FLUSH; else score>stall_thresh -> STALL.
//   STALL: score>flush_thresh -> FLUSH; score<lo(stall_thresh) -> NORM; else stay.
//   FLUSH: score<lo(flush_thresh) -> (score>stall_thresh ? STALL : NORM); else stay.
//   CRIT:  hold_cnt decrements every clock regardless of valid; at hold_cnt==1 -> NORM.
//   Non-anomaly scores are ignored while in CRIT.
// - No score_valid: state holds, except the CRIT countdown.
// - Flush compare precedes stall compare; stall_thresh >= flush_thresh yields flush.
// - Outputs registered, decoded from state. flush = FLUSH|CRIT; stall = STALL; never both high; hazard_level = state code.
// - flush_events += 1 on each NORM/STALL -> FLUSH/CRIT transition, and on each CRIT reload. Saturates at all-ones.
// STRUCTURE
// - archon_hazard_pkg: state codes (NORM=00, STALL=01, FLUSH=10, CRIT=11), hazard level constants, default-weight function, clog2 helper.
// - Sub-module archon_weighted_score_pipe: weight table, config port, S1/S2 multiply-accumulate.
//   Outputs score/score_valid/anomaly to the FSM in the top.
// TESTING (NUM_CH=5, MW=8, WW=4, HOLD_CYCLES=8)
// 1 Reset defaults: all metrics 10, flush 1000, stall 300 -> score 400, score_valid cycle 2; stall=1, level 01 at cycle 3.
// 2 Hysteresis, stall 300, hyst 50, in STALL: score 280 -> stays STALL; score 240 -> NORM, stall drops.
// 3 Anomaly with score 0 -> flush=1, level 11 for 8 cycles then 0. Second anomaly at hold cycle 4 -> total hold extends 4+8.
// 4 Write mode1/ch0 = 15, mode=1, ch0=255, others 0 -> score 3825.
//   Write plus sample in the same cycle -> score 255*8 = 2040.
// 5 All metrics 255, all weights 15 -> score 19125 (no wrap); flush 19124 -> flush; flush 19125 -> none.
// 6 rst mid-STALL with sample in flight -> outputs 0 async, no score_valid for that sample.
//   Force 2**CNT_W flush entries -> flush_events stays all-ones.

Source files
------------

// File: rtl/archon_hazard_pkg.sv
// Shared types and helpers for the hazard override engine: FSM state codes,
// hazard level encodings, default weight and clog2.
package archon_hazard_pkg;

    typedef enum logic [1:0] {
        ST_NORM  = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10,
        ST_CRIT  = 2'b11
    } hz_state_e;

    localparam logic [1:0] LVL_NONE  = 2'b00;
    localparam logic [1:0] LVL_STALL = 2'b01;
    localparam logic [1:0] LVL_FLUSH = 2'b10;
    localparam logic [1:0] LVL_CRIT  = 2'b11;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Mid-scale weight, so an unprogrammed table still scores every channel.
    function automatic int def_weight(input int ww);
        return 1 << (ww - 1);
    endfunction

endpackage

// File: rtl/archon_hazard_override_engine_if.sv
// Sample, weight-config, threshold and override signals of the engine.
// slave = engine side, master = the block driving samples and config.
interface archon_hazard_override_engine_if #(
    parameter int NUM_CH    = 5,
    parameter int MW        = 8,
    parameter int WW        = 4,
    parameter int NUM_MODES = 4,
    parameter int CNT_W     = 16
);
    localparam int MODEW = archon_hazard_pkg::clog2(NUM_MODES);
    localparam int CHW   = archon_hazard_pkg::clog2(NUM_CH);
    localparam int SW    = MW + WW + archon_hazard_pkg::clog2(NUM_CH);

    logic                   metric_valid;
    logic [NUM_CH*MW-1:0]   metrics_flat;
    logic                   anomaly_in;
    logic [MODEW-1:0]       mode;
    logic                   cfg_we;
    logic [MODEW-1:0]       cfg_mode;
    logic [CHW-1:0]         cfg_ch;
    logic [WW-1:0]          cfg_weight;
    logic [SW-1:0]          flush_thresh;
    logic [SW-1:0]          stall_thresh;
    logic [SW-1:0]          hyst;
    logic [SW-1:0]          score_out;
    logic                   score_valid;
    logic                   override_flush;
    logic                   override_stall;
    logic [1:0]             hazard_level;
    logic [CNT_W-1:0]       flush_events;

    modport slave (
        input  metric_valid, metrics_flat, anomaly_in, mode,
        input  cfg_we, cfg_mode, cfg_ch, cfg_weight,
        input  flush_thresh, stall_thresh, hyst,
        output score_out, score_valid, override_flush, override_stall,
        output hazard_level, flush_events
    );

    modport master (
        output metric_valid, metrics_flat, anomaly_in, mode,
        output cfg_we, cfg_mode, cfg_ch, cfg_weight,
        output flush_thresh, stall_thresh, hyst,
        input  score_out, score_valid, override_flush, override_stall,
        input  hazard_level, flush_events
    );

endinterface

// File: rtl/archon_weighted_score_pipe.sv
// Per-mode weight table plus the two-stage multiply/accumulate that turns a
// metric sample into an exact weighted hazard score.
module archon_weighted_score_pipe
    import archon_hazard_pkg::*;
#(
    parameter int NUM_CH    = 5,
    parameter int MW        = 8,
    parameter int WW        = 4,
    parameter int NUM_MODES = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  metric_valid,
    input  logic [NUM_CH*MW-1:0]                  metrics_flat,
    input  logic                                  anomaly_in,
    input  logic [clog2(NUM_MODES)-1:0]           mode,
    input  logic                                  cfg_we,
    input  logic [clog2(NUM_MODES)-1:0]           cfg_mode,
    input  logic [clog2(NUM_CH)-1:0]              cfg_ch,
    input  logic [WW-1:0]                         cfg_weight,
    output logic [MW+WW+clog2(NUM_CH)-1:0]        score,
    output logic                                  score_valid,
    output logic                                  anomaly
);
    localparam int PW     = MW + WW;
    localparam int SW     = MW + WW + clog2(NUM_CH);
    localparam int STAGES = 2;
    localparam logic [WW-1:0] DEF_W = WW'(def_weight(WW));

    logic [NUM_MODES-1:0][NUM_CH-1:0][WW-1:0] wtab;
    logic [NUM_CH-1:0][PW-1:0]                prod;
    logic [STAGES:1]                          vld_pipe;
    logic [STAGES:1]                          anom_pipe;
    logic [SW-1:0]                            sum;

    // Write lands at the edge, so a sample in the same cycle sees the old weight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int m = 0; m < NUM_MODES; m++)
                for (int c = 0; c < NUM_CH; c++)
                    wtab[m][c] <= DEF_W;
        end else if (cfg_we && (int'(cfg_ch) < NUM_CH)) begin
            wtab[cfg_mode][cfg_ch] <= cfg_weight;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod <= '0;
        end else if (metric_valid) begin
            for (int i = 0; i < NUM_CH; i++)
                prod[i] <= PW'(metrics_flat[i*MW +: MW]) * PW'(wtab[mode][i]);
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_CH; i++)
            sum = sum + SW'(prod[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            anom_pipe <= '0;
            score     <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[1], metric_valid};
            anom_pipe <= {anom_pipe[1], metric_valid & anomaly_in};
            if (vld_pipe[1]) score <= sum;
        end
    end

    assign score_valid = vld_pipe[STAGES];
    assign anomaly     = anom_pipe[STAGES];

endmodule

// File: rtl/archon_hazard_override_engine.sv
// Hazard override engine: weighted score pipe feeding a NORM/STALL/FLUSH/CRIT
// override FSM with hysteresis, anomaly hold-off and a flush-entry counter.
module archon_hazard_override_engine
    import archon_hazard_pkg::*;
#(
    parameter int NUM_CH      = 5,
    parameter int MW          = 8,
    parameter int WW          = 4,
    parameter int NUM_MODES   = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int CNT_W       = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    archon_hazard_override_engine_if.slave bus
);
    localparam int SW = MW + WW + clog2(NUM_CH);
    localparam int HW = clog2(HOLD_CYCLES + 1);

    logic [SW-1:0]    score;
    logic             score_valid;
    logic             anomaly;
    hz_state_e        state, nxt;
    logic [HW-1:0]    hold_cnt, hold_nxt;
    logic             bump;
    logic             flush_r, stall_r;
    logic [1:0]       level_r, level_nxt;
    logic [CNT_W-1:0] events;
    logic [SW-1:0]    lo_flush, lo_stall;

    archon_weighted_score_pipe #(
        .NUM_CH    (NUM_CH),
        .MW        (MW),
        .WW        (WW),
        .NUM_MODES (NUM_MODES)
    ) u_pipe (
        .clk          (clk),
        .rst          (rst),
        .metric_valid (bus.metric_valid),
        .metrics_flat (bus.metrics_flat),
        .anomaly_in   (bus.anomaly_in),
        .mode         (bus.mode),
        .cfg_we       (bus.cfg_we),
        .cfg_mode     (bus.cfg_mode),
        .cfg_ch       (bus.cfg_ch),
        .cfg_weight   (bus.cfg_weight),
        .score        (score),
        .score_valid  (score_valid),
        .anomaly      (anomaly)
    );

    function automatic logic [SW-1:0] lo(input logic [SW-1:0] t, input logic [SW-1:0] h);
        return (t > h) ? t - h : '0;
    endfunction

    assign lo_flush = lo(bus.flush_thresh, bus.hyst);
    assign lo_stall = lo(bus.stall_thresh, bus.hyst);

    always_comb begin
        nxt      = state;
        hold_nxt = hold_cnt;
        bump     = 1'b0;
        if (state == ST_CRIT) begin
            // Countdown runs every clock; only a fresh anomaly can interrupt it.
            if (score_valid && anomaly) begin
                hold_nxt = HW'(HOLD_CYCLES);
                bump     = 1'b1;
            end else if (hold_cnt == HW'(1)) begin
                nxt      = ST_NORM;
                hold_nxt = '0;
            end else begin
                hold_nxt = hold_cnt - HW'(1);
            end
        end else if (score_valid) begin
            if (anomaly) begin
                nxt      = ST_CRIT;
                hold_nxt = HW'(HOLD_CYCLES);
            end else begin
                unique case (state)
                    ST_NORM:
                        if (score > bus.flush_thresh)      nxt = ST_FLUSH;
                        else if (score > bus.stall_thresh) nxt = ST_STALL;
                    ST_STALL:
                        if (score > bus.flush_thresh)      nxt = ST_FLUSH;
                        else if (score < lo_stall)         nxt = ST_NORM;
                    ST_FLUSH:
                        if (score < lo_flush)
                            nxt = (score > bus.stall_thresh) ? ST_STALL : ST_NORM;
                    default: ;
                endcase
            end
            bump = (nxt == ST_FLUSH || nxt == ST_CRIT) && (state != ST_FLUSH);
        end
    end

    always_comb begin
        level_nxt = LVL_NONE;
        unique case (nxt)
            ST_NORM:  level_nxt = LVL_NONE;
            ST_STALL: level_nxt = LVL_STALL;
            ST_FLUSH: level_nxt = LVL_FLUSH;
            ST_CRIT:  level_nxt = LVL_CRIT;
            default:  level_nxt = LVL_NONE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_NORM;
            hold_cnt <= '0;
            flush_r  <= 1'b0;
            stall_r  <= 1'b0;
            level_r  <= LVL_NONE;
            events   <= '0;
        end else begin
            state    <= nxt;
            hold_cnt <= hold_nxt;
            flush_r  <= (nxt == ST_FLUSH) || (nxt == ST_CRIT);
            stall_r  <= (nxt == ST_STALL);
            level_r  <= level_nxt;
            if (bump && !(&events)) events <= events + CNT_W'(1);
        end
    end

    assign bus.score_out      = score;
    assign bus.score_valid    = score_valid;
    assign bus.override_flush = flush_r;
    assign bus.override_stall = stall_r;
    assign bus.hazard_level   = level_r;
    assign bus.flush_events   = events;

endmodule

// File: tb/tb_archon_hazard_override_engine.sv
// Directed scenarios plus randomized traffic against a cycle-level
// reference model of the scoring and override rules.
module tb_archon_hazard_override_engine;
    localparam int NUM_CH = 5, MW = 8, WW = 4, NUM_MODES = 4, HOLD = 8, CNT_W = 8;
    localparam int SW = MW + WW + 3, MODEW = 2, CHW = 3;
    localparam int EVMAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    archon_hazard_override_engine_if #(
        .NUM_CH(NUM_CH), .MW(MW), .WW(WW), .NUM_MODES(NUM_MODES), .CNT_W(CNT_W)
    ) bus ();

    archon_hazard_override_engine #(
        .NUM_CH(NUM_CH), .MW(MW), .WW(WW), .NUM_MODES(NUM_MODES),
        .HOLD_CYCLES(HOLD), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { int due; int score; bit an; } smp_t;

    int   checks = 0, failures = 0;
    int   cyc = 0;
    smp_t pq[$];
    int   m_w[NUM_MODES][NUM_CH];
    int   m_st, m_hold, m_ev;
    int   n;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < NUM_MODES; m++)
            for (int c = 0; c < NUM_CH; c++) m_w[m][c] = 1 << (WW - 1);
        m_st = 0; m_hold = 0; m_ev = 0;
        pq.delete();
    endtask

    function automatic int mscore();
        int s = 0;
        for (int i = 0; i < NUM_CH; i++)
            s += int'(bus.metrics_flat[i*MW +: MW]) * m_w[bus.mode][i];
        return s;
    endfunction

    function automatic int lo(input int t, input int h);
        return (t > h) ? t - h : 0;
    endfunction

    // States: 0 none, 1 stall, 2 flush, 3 critical.
    task automatic mstep(input bit sv, input int sc, input bit an);
        int ft, st, hy, nx;
        ft = int'(bus.flush_thresh); st = int'(bus.stall_thresh); hy = int'(bus.hyst);
        if (m_st == 3) begin
            if (sv && an) begin m_hold = HOLD; if (m_ev < EVMAX) m_ev++; end
            else if (m_hold == 1) begin m_st = 0; m_hold = 0; end
            else m_hold--;
        end else if (sv) begin
            nx = m_st;
            if (an) begin nx = 3; m_hold = HOLD; end
            else if (sc > ft && m_st != 2) nx = 2;
            else if (m_st == 0 && sc > st) nx = 1;
            else if (m_st == 1 && sc < lo(st, hy)) nx = 0;
            else if (m_st == 2 && sc < lo(ft, hy)) nx = (sc > st) ? 1 : 0;
            if (nx >= 2 && m_st != 2 && m_ev < EVMAX) m_ev++;
            m_st = nx;
        end
    endtask

    task automatic tick();
        bit sv; int sc; bit an;
        sv = 0; sc = 0; an = 0;
        if (pq.size() > 0 && pq[0].due == cyc) begin
            sv = 1; sc = pq[0].score; an = pq[0].an; pq.delete(0);
        end
        chk("score_valid", bus.score_valid, sv);
        if (sv) chk("score_out", bus.score_out, sc);
        mstep(sv, sc, an);
        if (bus.metric_valid) pq.push_back('{cyc + 2, mscore(), bus.anomaly_in});
        if (bus.cfg_we && int'(bus.cfg_ch) < NUM_CH) m_w[bus.cfg_mode][bus.cfg_ch] = int'(bus.cfg_weight);
        @(posedge clk);
        cyc++;
        #1;
        chk("flush", bus.override_flush, (m_st >= 2));
        chk("stall", bus.override_stall, (m_st == 1));
        chk("level", bus.hazard_level, m_st);
        chk("events", bus.flush_events, m_ev);
    endtask

    task automatic idle(input int k);
        repeat (k) tick();
    endtask

    task automatic set_m(input int v);
        for (int i = 0; i < NUM_CH; i++) bus.metrics_flat[i*MW +: MW] = MW'(v);
    endtask

    task automatic set_m1(input int v);
        bus.metrics_flat = '0;
        bus.metrics_flat[MW-1:0] = MW'(v);
    endtask

    task automatic thr(input int f, input int s, input int h);
        bus.flush_thresh = SW'(f); bus.stall_thresh = SW'(s); bus.hyst = SW'(h);
    endtask

    task automatic sample(input bit an, input int md);
        bus.metric_valid = 1'b1; bus.anomaly_in = an; bus.mode = MODEW'(md);
        tick();
        bus.metric_valid = 1'b0; bus.anomaly_in = 1'b0;
    endtask

    task automatic wr(input int md, input int ch, input int w);
        bus.cfg_we = 1'b1; bus.cfg_mode = MODEW'(md); bus.cfg_ch = CHW'(ch); bus.cfg_weight = WW'(w);
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic crit_run(input int n0, output int cnt);
        cnt = n0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.hazard_level == 2'b11) cnt++;
            else break;
        end
    endtask

    initial begin
        bus.metric_valid = 0; bus.metrics_flat = '0; bus.anomaly_in = 0; bus.mode = '0;
        bus.cfg_we = 0; bus.cfg_mode = '0; bus.cfg_ch = '0; bus.cfg_weight = '0;
        thr(1000, 300, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_flush", bus.override_flush, 0);
        chk("rst_stall", bus.override_stall, 0);
        chk("rst_level", bus.hazard_level, 0);
        chk("rst_events", bus.flush_events, 0);
        chk("rst_sv", bus.score_valid, 0);
        rst = 1'b0;

        // Default weights: 5 * 10 * 8 = 400 lands between stall and flush.
        set_m(10);
        sample(0, 0);
        tick();
        chk("t1_sv", bus.score_valid, 1);
        chk("t1_score", bus.score_out, 400);
        tick();
        chk("t1_level", bus.hazard_level, 1);

        // Hysteresis: lo(300) = 250.
        thr(1000, 300, 50);
        set_m1(35); sample(0, 0); idle(2);
        chk("t2_hold_stall", bus.override_stall, 1);
        set_m1(30); sample(0, 0); idle(2);
        chk("t2_drop_stall", bus.override_stall, 0);
        chk("t2_level", bus.hazard_level, 0);

        // Anomaly hold-off, then a reload four cycles into the hold.
        set_m(0);
        sample(1, 0); idle(2);
        chk("t3_level", bus.hazard_level, 3);
        crit_run(1, n);
        chk("t3_crit_cycles", n, 8);
        sample(1, 0); idle(2);
        chk("t3b_level", bus.hazard_level, 3);
        tick();
        sample(1, 0);
        crit_run(3, n);
        chk("t3b_crit_cycles", n, 12);

        // Weight programming, same-cycle write, out-of-range channel.
        thr(20000, 20000, 0);
        wr(1, 0, 15);
        set_m1(255); sample(0, 1); tick();
        chk("t4_score", bus.score_out, 3825);
        bus.cfg_we = 1; bus.cfg_mode = 2'd2; bus.cfg_ch = 3'd0; bus.cfg_weight = 4'd15;
        sample(0, 2);
        bus.cfg_we = 0;
        tick();
        chk("t4_old_weight", bus.score_out, 2040);
        sample(0, 2); tick();
        chk("t4_new_weight", bus.score_out, 3825);
        wr(0, 5, 1); wr(0, 7, 0);
        set_m(255); sample(0, 0); tick();
        chk("t4_bad_ch", bus.score_out, 10200);
        idle(2);

        // Full-scale score and the strict flush compare.
        for (int c = 0; c < NUM_CH; c++) wr(3, c, 15);
        thr(19124, 19125, 0);
        set_m(255); sample(0, 3); tick();
        chk("t5_score", bus.score_out, 19125);
        tick();
        chk("t5_flush", bus.override_flush, 1);
        chk("t5_level", bus.hazard_level, 2);
        set_m(0); sample(0, 3); idle(2);
        chk("t5_back_norm", bus.hazard_level, 0);
        thr(19125, 19125, 0);
        set_m(255); sample(0, 3); idle(2);
        chk("t5_eq_none", bus.override_flush, 0);
        chk("t5_eq_level", bus.hazard_level, 0);

        // Asynchronous reset with a sample in flight.
        thr(1000, 300, 0);
        set_m(10); sample(0, 0); idle(2);
        chk("t6_stall", bus.override_stall, 1);
        sample(0, 0);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_stall", bus.override_stall, 0);
        chk("t6_rst_level", bus.hazard_level, 0);
        chk("t6_rst_score", bus.score_out, 0);
        chk("t6_rst_sv", bus.score_valid, 0);
        model_reset();
        #1 rst = 1'b0;
        idle(4);

        // Back-to-back anomalies each reload CRIT and count until saturation.
        set_m(0);
        bus.metric_valid = 1; bus.anomaly_in = 1; bus.mode = '0;
        idle(300);
        bus.metric_valid = 0; bus.anomaly_in = 0;
        idle(12);
        chk("t6_events_sat", bus.flush_events, EVMAX);

        // Randomized traffic, config writes and threshold changes.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(39) == 0)
                thr($urandom_range(14000), $urandom_range(10000), $urandom_range(1500));
            bus.metric_valid = ($urandom_range(9) < 7);
            bus.anomaly_in   = ($urandom_range(49) == 0);
            bus.mode         = MODEW'($urandom);
            for (int i = 0; i < NUM_CH; i++) bus.metrics_flat[i*MW +: MW] = MW'($urandom);
            bus.cfg_we     = ($urandom_range(7) == 0);
            bus.cfg_mode   = MODEW'($urandom);
            bus.cfg_ch     = CHW'($urandom);
            bus.cfg_weight = WW'($urandom);
            tick();
        end
        bus.metric_valid = 0; bus.anomaly_in = 0; bus.cfg_we = 0;
        idle(15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
